// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus host arbiter.
// Round-robin pick function and index-width helper.
package bus_arb_pkg;

    localparam int unsigned MaxHosts = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } pick_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester at or after ptr, scanning upward and wrapping at n.
    function automatic pick_t rr_pick(
        input logic [MaxHosts-1:0] req,
        input int                  ptr,
        input int                  n
    );
        pick_t p;
        int    h;
        p = '0;
        for (int k = MaxHosts - 1; k >= 0; k--) begin
            if (k < n) begin
                h = ptr + k;
                if (h >= n) h = h - n;
                if (req[h]) begin
                    p.valid = 1'b1;
                    p.idx   = 5'(h);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Response-routing FIFO of host IDs.
// Same-cycle push and pop is accepted even when full.
module bus_arb_id_fifo #(
    parameter int Depth = 2,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = do_push ? nxt(wptr_q) : wptr_q;
        rptr_d = do_pop ? nxt(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + CntW'(1);
        if (!do_push && do_pop) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one Ibex-protocol device port
// between several hosts, with in-order response routing.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int AddressWidth   = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NrHosts-1:0]      host_req_i,
    input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]      host_we_i,
    input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]      host_gnt_o,
    output logic [NrHosts-1:0]      host_rvalid_o,
    output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]      host_err_o,
    output logic                    dev_req_o,
    output logic [AddressWidth-1:0] dev_addr_o,
    output logic                    dev_we_o,
    output logic [DataWidth/8-1:0]  dev_be_o,
    output logic [DataWidth-1:0]    dev_wdata_o,
    input  logic                    dev_gnt_i,
    input  logic                    dev_rvalid_i,
    input  logic [DataWidth-1:0]    dev_rdata_i,
    input  logic                    dev_err_i
);

    localparam int IdxW = idx_w(NrHosts);

    logic [IdxW-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d;
    logic            locked_q, locked_d;
    pick_t           pick;
    logic [IdxW-1:0] win, head;
    logic            win_vld, empty, full, pop, full_eff, hs;

    assign pick    = rr_pick(MaxHosts'(host_req_i), int'(ptr_q), NrHosts);
    assign win     = locked_q ? lock_idx_q : IdxW'(pick.idx);
    assign win_vld = locked_q | pick.valid;

    // A pop in the same cycle frees the slot the new push needs.
    assign pop       = dev_rvalid_i & ~empty & ~rst_i;
    assign full_eff  = full & ~pop;
    assign dev_req_o = win_vld & ~full_eff & ~rst_i;
    assign hs        = dev_req_o & dev_gnt_i;

    assign dev_addr_o  = rst_i ? '0 : host_addr_i[win];
    assign dev_we_o    = rst_i ? 1'b0 : host_we_i[win];
    assign dev_be_o    = rst_i ? '0 : host_be_i[win];
    assign dev_wdata_o = rst_i ? '0 : host_wdata_i[win];

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (hs) host_gnt_o[win] = 1'b1;
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
            host_err_o[head]    = dev_err_i;
        end
        for (int i = 0; i < NrHosts; i++) begin
            host_rdata_o[i] = rst_i ? '0 : dev_rdata_i;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            ptr_d    = (win == IdxW'(NrHosts - 1)) ? '0 : win + IdxW'(1);
            locked_d = 1'b0;
        end else if (dev_req_o) begin
            locked_d   = 1'b1;
            lock_idx_d = win;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .pop_i   (pop),
        .wdata_i (win),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(dev_rvalid_i && empty))
                else $warning("bus_host_arbiter: response with nothing outstanding");
            assert (!(locked_q && !host_req_i[lock_idx_q]))
                else $warning("bus_host_arbiter: locked host dropped its request");
        end
    end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Bench for bus_host_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_bus_host_arbiter;

    localparam int N  = 2;
    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] addr [N];
    logic [3:0]  be   [N];
    logic [31:0] wdata[N];
    logic [1:0]  gnt, rvalid, err;
    logic [31:0] rdata_o [N];
    logic        dev_req, dev_we;
    logic [31:0] dev_addr, dev_wdata;
    logic [3:0]  dev_be;
    logic        dev_gnt, dev_rvalid, dev_err;
    logic [31:0] dev_rdata;

    int checks = 0;
    int errors = 0;

    int mq[$];
    int m_ptr    = 0;
    bit m_locked = 0;
    int m_lidx   = 0;

    always #5 clk = ~clk;

    bus_host_arbiter #(
        .NrHosts(N), .AddressWidth(32), .DataWidth(32), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(req), .host_addr_i(addr), .host_we_i(we),
        .host_be_i(be), .host_wdata_i(wdata),
        .host_gnt_o(gnt), .host_rvalid_o(rvalid),
        .host_rdata_o(rdata_o), .host_err_o(err),
        .dev_req_o(dev_req), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
        .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
        .dev_rdata_i(dev_rdata), .dev_err_i(dev_err)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluated on the falling edge, then advanced.
    always @(negedge clk) begin : cmp
        logic [1:0] eg, erv, eer;
        bit         pop, fe, vld, ereq, hs;
        int         w, h;
        eg = '0; erv = '0; eer = '0;
        if (rst) begin
            chk("rst_dev_req", dev_req, 0);
            chk("rst_gnt", gnt, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_err", err, 0);
            chk("rst_rdata", {rdata_o[1], rdata_o[0]}, 0);
            chk("rst_payload", {dev_addr, dev_wdata, dev_be, dev_we}, 0);
            mq.delete();
            m_ptr = 0; m_locked = 0; m_lidx = 0;
        end else begin
            pop = dev_rvalid && (mq.size() > 0);
            fe  = (mq.size() >= MO) && !pop;
            vld = 0; w = 0;
            if (m_locked) begin
                vld = 1; w = m_lidx;
            end else begin
                for (int k = 0; k < N; k++) begin
                    h = (m_ptr + k) % N;
                    if (!vld && req[h]) begin vld = 1; w = h; end
                end
            end
            ereq = vld && !fe;
            hs   = ereq && dev_gnt;
            if (hs) eg[w] = 1'b1;
            if (pop) begin
                erv[mq[0]] = 1'b1;
                eer[mq[0]] = dev_err;
            end
            chk("m_dev_req", dev_req, ereq);
            chk("m_gnt", gnt, eg);
            chk("m_rvalid", rvalid, erv);
            chk("m_err", err, eer);
            chk("m_rdata", {rdata_o[1], rdata_o[0]}, {dev_rdata, dev_rdata});
            if (ereq)
                chk("m_payload", {dev_addr, dev_wdata, dev_be, dev_we},
                    {addr[w], wdata[w], be[w], we[w]});
            if (pop) void'(mq.pop_front());
            if (hs) begin
                mq.push_back(w);
                m_ptr = (w + 1) % N;
                m_locked = 0;
            end else if (ereq) begin
                m_locked = 1; m_lidx = w;
            end
        end
    end

    task automatic idle();
        req = '0; dev_gnt = 0; dev_rvalid = 0; dev_rdata = '0; dev_err = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; idle();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic drive(input logic [1:0] r, input logic [31:0] a0, a1,
                         input logic g, rv, input logic [31:0] rd,
                         input logic e);
        @(posedge clk); #1;
        req = r; addr[0] = a0; addr[1] = a1;
        dev_gnt = g; dev_rvalid = rv; dev_rdata = rd; dev_err = e;
        @(negedge clk);
    endtask

    logic [1:0] g_seen, pend;

    initial begin
        rst = 1; idle();
        addr[0] = '0; addr[1] = '0;
        we = 2'b10; be[0] = 4'hF; be[1] = 4'h3;
        wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Single host, back-to-back reads with next-cycle responses
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive((c < 3) ? 2'b01 : 2'b00, 32'h100 + 32'(4 * c), 32'h0,
                  1, c > 0, 32'(c), 0);
            chk("t1_gnt", gnt, (c < 3) ? 2'b01 : 2'b00);
            chk("t1_rvalid", rvalid, (c > 0) ? 2'b01 : 2'b00);
            if (c < 3) chk("t1_addr", dev_addr, 32'h100 + 32'(4 * c));
        end

        // Fairness
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 32'h200, 32'h300, 1, c > 0, 0, 0);
            chk("t2_gnt", gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
            if (c > 0) chk("t2_rvalid", rvalid, (c % 2 == 1) ? 2'b01 : 2'b10);
        end
        drive(2'b00, 0, 0, 0, 1, 0, 0);
        chk("t2_last_rvalid", rvalid, 2'b10);

        // Lock holds host1 while host0 joins
        do_reset();
        drive(2'b10, 32'hA0, 32'hB0, 0, 0, 0, 0);
        chk("t3_addr0", dev_addr, 32'hB0);
        chk("t3_gnt0", gnt, 2'b00);
        drive(2'b11, 32'hA0, 32'hB0, 0, 0, 0, 0);
        chk("t3_addr1", dev_addr, 32'hB0);
        drive(2'b11, 32'hA0, 32'hB0, 0, 0, 0, 0);
        chk("t3_addr2", dev_addr, 32'hB0);
        drive(2'b11, 32'hA0, 32'hB0, 1, 0, 0, 0);
        chk("t3_gnt_h1", gnt, 2'b10);
        drive(2'b01, 32'hA0, 32'hB0, 1, 0, 0, 0);
        chk("t3_gnt_h0", gnt, 2'b01);
        chk("t3_addr_h0", dev_addr, 32'hA0);
        drive(2'b00, 0, 0, 0, 1, 0, 0);
        chk("t3_rv1", rvalid, 2'b10);
        drive(2'b00, 0, 0, 0, 1, 0, 0);
        chk("t3_rv2", rvalid, 2'b01);

        // Backpressure from the ID FIFO
        do_reset();
        drive(2'b01, 32'h40, 0, 1, 0, 0, 0);
        chk("t4_gnt0", gnt, 2'b01);
        drive(2'b01, 32'h44, 0, 1, 0, 0, 0);
        chk("t4_gnt1", gnt, 2'b01);
        drive(2'b01, 32'h48, 0, 1, 0, 0, 0);
        chk("t4_req_full", dev_req, 0);
        chk("t4_gnt_full", gnt, 2'b00);
        drive(2'b01, 32'h48, 0, 1, 1, 32'hDEADBEEF, 1);
        chk("t4_rvalid", rvalid, 2'b01);
        chk("t4_err", err, 2'b01);
        chk("t4_rdata", rdata_o[0], 32'hDEADBEEF);
        chk("t4_regrant", gnt, 2'b01);
        drive(2'b00, 0, 0, 0, 1, 0, 0);
        chk("t4_err_clr", err, 2'b00);
        drive(2'b00, 0, 0, 0, 1, 0, 0);
        chk("t4_rv_last", rvalid, 2'b01);

        // Mixed routing 1, 0, 1
        do_reset();
        drive(2'b10, 0, 32'h10, 1, 0, 0, 0);
        chk("t5_gnt0", gnt, 2'b10);
        drive(2'b01, 32'h20, 0, 1, 1, 0, 0);
        chk("t5_gnt1", gnt, 2'b01);
        chk("t5_rv0", rvalid, 2'b10);
        drive(2'b10, 0, 32'h30, 1, 1, 0, 0);
        chk("t5_gnt2", gnt, 2'b10);
        chk("t5_rv1", rvalid, 2'b01);
        drive(2'b00, 0, 0, 0, 1, 0, 0);
        chk("t5_rv2", rvalid, 2'b10);

        // Reset with two outstanding
        do_reset();
        drive(2'b01, 32'h50, 0, 1, 0, 0, 0);
        drive(2'b01, 32'h54, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1; req = 2'b11; dev_gnt = 1; dev_rvalid = 1;
        dev_rdata = 32'hCAFE0000; dev_err = 1;
        @(negedge clk);
        chk("t6_req", dev_req, 0);
        chk("t6_rvalid", rvalid, 2'b00);
        chk("t6_rdata", rdata_o[0], 32'h0);
        @(posedge clk); #1;
        rst = 0; req = 2'b00; dev_gnt = 0;
        @(negedge clk);
        chk("t6_stray", rvalid, 2'b00);
        chk("t6_rdata_thru", rdata_o[0], 32'hCAFE0000);
        drive(2'b11, 32'h60, 32'h70, 1, 0, 0, 0);
        chk("t6_ptr0", gnt, 2'b01);
        drive(2'b00, 0, 0, 0, 1, 0, 0);
        chk("t6_rv", rvalid, 2'b01);

        // Randomized traffic
        pend = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            g_seen = gnt;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            for (int h = 0; h < N; h++) begin
                if (!(pend[h] && !g_seen[h])) begin
                    req[h]   = ($urandom_range(0, 2) != 0);
                    addr[h]  = $urandom;
                    wdata[h] = $urandom;
                    be[h]    = 4'($urandom);
                    we[h]    = 1'($urandom);
                    pend[h]  = req[h];
                end
            end
            if (rst) pend = '0;
            dev_gnt    = ($urandom_range(0, 3) != 0);
            dev_rvalid = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            dev_rdata  = $urandom;
            dev_err    = 1'($urandom);
        end

        @(posedge clk); #1;
        idle();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
